// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM burst reader: default sizes,
// address-width derivation and the reader FSM encoding.
package dpram_pkg;

    localparam int unsigned DefaultDataSize = 16;
    localparam int unsigned DefaultDepth    = 16;

    // Address width for a RAM of the given depth (at least one bit).
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain
    } state_e;

endpackage

// File: rtl/burst_skid_fifo.sv
// Two-entry FIFO buffering RAM read data (plus end-of-burst flag) in front of
// the output stream. The caller guarantees no push when full and no pop when
// empty.
module burst_skid_fifo #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             push_last_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output logic             last_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] data_q [2];
    logic [1:0]       last_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    // Storage, pointers and occupancy; push and pop in one cycle keep the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
            end
            last_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                data_q[wr_ptr_q] <= push_data_i;
                last_q[wr_ptr_q] <= push_last_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    // Head of queue drives the stream directly.
    always_comb begin
        valid_o = (count_q != 2'd0);
        data_o  = data_q[rd_ptr_q];
        last_o  = last_q[rd_ptr_q] & valid_o;
        count_o = count_q;
    end

endmodule

// File: rtl/dpram_burst_reader.sv
// Reads a burst of consecutive words (wrapping at DEPTH) from a RAM with
// one-cycle read latency and streams them out with valid/ready handshaking.
// At most two words are ever outstanding or buffered.
module dpram_burst_reader
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DefaultDataSize,
    parameter int unsigned DEPTH     = DefaultDepth,
    parameter int unsigned ADDR_W    = addr_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      burst_len,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_rd_addr,
    input  logic [DATA_SIZE-1:0] mem_rd_data,
    output logic                 m_valid,
    output logic [DATA_SIZE-1:0] m_data,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done
);

    localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LenOne   = (ADDR_W + 1)'(1);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remain_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              busy_q;
    logic              done_q;

    logic              pop;
    logic              issue;
    logic [2:0]        occupancy;
    logic [1:0]        fifo_count;

    // Issue a read only if buffered + in-flight words stay within the FIFO.
    // A pop this cycle frees a slot, which keeps a full-rate stream going.
    always_comb begin
        pop       = m_valid && m_ready;
        occupancy = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
        issue     = (state_q == StRead) && (occupancy < 3'd2);
    end

    // Burst FSM with registered status and read-address tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= issue;
            inflight_last_q <= issue && (remain_q == LenOne);
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            addr_q   <= base_addr;
                            remain_q <= burst_len;
                            busy_q   <= 1'b1;
                            state_q  <= StRead;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (issue) begin
                        addr_q   <= (addr_q == AddrLast) ? '0 : addr_q + AddrOne;
                        remain_q <= remain_q - LenOne;
                        if (remain_q == LenOne) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (pop && m_last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    burst_skid_fifo #(
        .Width (DATA_SIZE)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (inflight_q),
        .push_data_i (mem_rd_data),
        .push_last_i (inflight_last_q),
        .pop_i       (pop),
        .valid_o     (m_valid),
        .data_o      (m_data),
        .last_o      (m_last),
        .count_o     (fifo_count)
    );

    // Drive RAM and status ports.
    always_comb begin
        mem_rd_en   = issue;
        mem_rd_addr = addr_q;
        busy        = busy_q;
        done        = done_q;
    end

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Directed bench for dpram_burst_reader: a table of bursts with hand-computed
// first-valid cycle, final beat data and done cycle, plus a mid-burst reset.
module tb_dpram_burst_reader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  base_addr;
    logic [4:0]  burst_len;
    logic        mem_rd_en;
    logic [3:0]  mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_last;
    logic        m_ready;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    dpram_burst_reader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .base_addr   (base_addr),
        .burst_len   (burst_len),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: word i holds 16'hA000 + i, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 16'hA000 + 16'(mem_rd_addr);
    end

    initial mem_rd_data = 16'h0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a drive point (just after a rising edge); returns at one.
    // Cycle c counts edges since the edge that sampled start.
    task automatic run_burst(input int base, input int len, input bit stall,
                             input int restart_at, input int first_exp,
                             input int last_exp, input int done_exp, input string tag);
        int issued = 0, popped = 0, max_out = 0;
        int addr_err = 0, beat_err = 0, stall_err = 0;
        int first_valid = -1, last_data = -1, done_cycle = -1;
        int busy0 = -1, busy_done = -1, extra_done = 0;
        bit prev_stall = 1'b0;
        logic [15:0] prev_data = '0;
        logic [15:0] exp_d;
        start     = 1'b1;
        base_addr = 4'(base);
        burst_len = 5'(len);
        m_ready   = !stall;
        @(posedge clk); #1;
        for (int c = 0; c < 64; c++) begin
            m_ready = stall ? (c % 2 == 0) : 1'b1;
            if (c == restart_at) begin
                start     = 1'b1;
                base_addr = 4'd0;
                burst_len = 5'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (c == 0) busy0 = int'(busy);
            if (prev_stall && (!m_valid || m_data != prev_data)) stall_err++;
            if (issued - popped > max_out) max_out = issued - popped;
            if (mem_rd_en) begin
                if (mem_rd_addr != 4'((base + issued) % 16)) addr_err++;
                issued++;
            end
            if (m_valid && first_valid < 0) first_valid = c;
            if (m_valid && m_ready) begin
                exp_d = 16'hA000 + 16'((base + popped) % 16);
                if (m_data != exp_d || m_last != (popped == len - 1)) beat_err++;
                if (m_last) last_data = int'(m_data);
                popped++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (done_cycle >= 0) begin
                extra_done = int'(done) + int'(m_valid);
                @(posedge clk); #1;
                break;
            end
            if (done) begin
                done_cycle = c;
                busy_done  = int'(busy);
            end
            @(posedge clk); #1;
        end
        start   = 1'b0;
        m_ready = 1'b0;
        check({tag, "_beats"},       popped,      len);
        check({tag, "_reads"},       issued,      len);
        check({tag, "_beat_err"},    beat_err,    0);
        check({tag, "_addr_err"},    addr_err,    0);
        check({tag, "_stall_err"},   stall_err,   0);
        check({tag, "_max_out_ok"},  int'(max_out <= 2), 1);
        check({tag, "_first_valid"}, first_valid, first_exp);
        check({tag, "_last_data"},   last_data,   last_exp);
        check({tag, "_done_cycle"},  done_cycle,  done_exp);
        check({tag, "_busy_c0"},     busy0,       int'(len != 0));
        check({tag, "_busy_at_done"}, busy_done,  0);
        check({tag, "_done_width"},  extra_done,  0);
    endtask

    typedef struct {
        int    base;
        int    len;
        bit    stall;
        int    restart_at;
        int    first_exp;
        int    last_exp;
        int    done_exp;
        string tag;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        vecs[0] = '{4,  4,  1'b0, -1, 2,  'hA007, 6,  "b4l4"};
        vecs[1] = '{14, 5,  1'b0, -1, 2,  'hA002, 7,  "wrap"};
        vecs[2] = '{3,  6,  1'b1, -1, 2,  'hA008, 13, "stall"};
        vecs[3] = '{9,  0,  1'b0, -1, -1, -1,     0,  "len0"};
        vecs[4] = '{4,  4,  1'b0, 2,  2,  'hA007, 6,  "restart"};
        vecs[5] = '{8,  16, 1'b0, -1, 2,  'hA007, 18, "full"};
        vecs[6] = '{15, 1,  1'b0, -1, 2,  'hA00F, 3,  "single"};

        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        burst_len = '0;
        m_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              int'({busy, done, mem_rd_en, mem_rd_addr, m_valid, m_last, m_data}), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_burst(vecs[i].base, vecs[i].len, vecs[i].stall, vecs[i].restart_at,
                      vecs[i].first_exp, vecs[i].last_exp, vecs[i].done_exp, vecs[i].tag);
            @(posedge clk); #1;
        end

        // Reset after the second beat of an 8-word burst.
        start     = 1'b1;
        base_addr = 4'd4;
        burst_len = 5'd8;
        m_ready   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            #1;
            if (m_valid && m_ready) n++;
            @(posedge clk); #1;
        end
        check("midburst_two_beats", n, 2);
        reset_n = 1'b0;
        #1;
        check("midburst_reset_outputs",
              int'({busy, done, mem_rd_en, mem_rd_addr, m_valid, m_last, m_data}), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_ready = 1'b0;
        @(posedge clk); #1;
        check("stale_after_reset", int'({m_valid, busy, mem_rd_en}), 0);
        run_burst(0, 2, 1'b0, -1, 2, 'hA001, 4, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
